// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the key-schedule blocks.
//   AES_ROUNDS   - number of AES-128 rounds (10)
//   ks_state_t   - key-stream controller states (IDLE/FWD/STREAM/DONE)
//   rcon(idx)    - round constant for schedule step idx (0..9)
//   rot_word(w)  - cyclic left rotate of a 32-bit word by one byte
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ks_state_t;

  // Out-of-range indices return 0; the key stream never uses them
  // in a step that reaches the output.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sbox.sv
// sbox: AES forward S-box, pure combinational lookup.
//   a - input byte
//   y - substituted byte
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX_TABLE[a];

endmodule

// File: rtl/aes_inv_key_stream.sv
// aes_inv_key_stream: AES-128 round keys delivered in decryption order.
// A forward pass walks the cipher key up to K10 (kept in k10_save), then
// each accepted handshake steps the key backwards, K10 down to K0.
//   clk, rst          - clock, asynchronous active-high reset
//   key_load, key     - capture a cipher key (word 0 in [127:96]), start pass
//   restart           - replay the stream from the saved K10
//   busy              - forward pass in progress
//   rk_valid/rk_ready - round-key handshake
//   rk, rk_idx        - current round key and its round index
//   rk_last           - rk_valid with rk_idx == 0
//
// state  | meaning
// IDLE   | no key loaded
// FWD    | forward pass, one schedule step per cycle
// STREAM | round key offered to the consumer
// DONE   | stream finished, K10 still held for replay
module aes_inv_key_stream
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic         restart,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

  ks_state_t    state;
  logic [3:0]   round_cnt;
  logic [127:0] work;
  logic [127:0] k10_save;
  logic [127:0] rk_q;
  logic [3:0]   rk_idx_q;
  logic         rk_valid_q;
  logic         busy_q;

  logic [31:0]  sub_in;
  logic [31:0]  sub_rot;
  logic [31:0]  sub_out;
  logic [127:0] fwd_next;
  logic [127:0] bwd_next;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [31:0]  bw0, bw1, bw2, bw3;

  // One SubWord serves both directions: during FWD it transforms w3 of the
  // working key; while streaming it transforms w3 ^ w2 of the output key,
  // which is w3 of the previous round key.
  assign sub_in  = (state == FWD) ? work[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
  assign sub_rot = rot_word(sub_in);

  sbox u_sbox_0 (.a(sub_rot[31:24]), .y(sub_out[31:24]));
  sbox u_sbox_1 (.a(sub_rot[23:16]), .y(sub_out[23:16]));
  sbox u_sbox_2 (.a(sub_rot[15:8]),  .y(sub_out[15:8]));
  sbox u_sbox_3 (.a(sub_rot[7:0]),   .y(sub_out[7:0]));

  // Forward step K(r-1) -> K(r), r = round_cnt.
  assign fw0      = work[127:96] ^ sub_out ^ {rcon(round_cnt - 4'd1), 24'h0};
  assign fw1      = work[95:64] ^ fw0;
  assign fw2      = work[63:32] ^ fw1;
  assign fw3      = work[31:0]  ^ fw2;
  assign fwd_next = {fw0, fw1, fw2, fw3};

  // Backward step K(i) -> K(i-1), i = rk_idx.
  assign bw3      = rk_q[31:0]  ^ rk_q[63:32];
  assign bw2      = rk_q[63:32] ^ rk_q[95:64];
  assign bw1      = rk_q[95:64] ^ rk_q[127:96];
  assign bw0      = rk_q[127:96] ^ sub_out ^ {rcon(rk_idx_q - 4'd1), 24'h0};
  assign bwd_next = {bw0, bw1, bw2, bw3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      round_cnt  <= 4'd0;
      work       <= 128'h0;
      k10_save   <= 128'h0;
      rk_q       <= 128'h0;
      rk_idx_q   <= 4'd0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (key_load) begin
      work       <= key;
      round_cnt  <= 4'd1;
      state      <= FWD;
      busy_q     <= 1'b1;
      rk_valid_q <= 1'b0;
    end else if (restart && (state == STREAM || state == DONE)) begin
      // A handshake in the same cycle is dropped: the replay wins.
      rk_q       <= k10_save;
      rk_idx_q   <= LAST_ROUND;
      rk_valid_q <= 1'b1;
      state      <= STREAM;
    end else begin
      case (state)
        FWD: begin
          work      <= fwd_next;
          round_cnt <= round_cnt + 4'd1;
          if (round_cnt == LAST_ROUND) begin
            k10_save   <= fwd_next;
            rk_q       <= fwd_next;
            rk_idx_q   <= LAST_ROUND;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (rk_idx_q != 4'd0) begin
              rk_q     <= bwd_next;
              rk_idx_q <= rk_idx_q - 4'd1;
            end else begin
              // K0 and index 0 stay visible on rk/rk_idx after the stream.
              state      <= DONE;
              rk_valid_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_valid_q & (rk_idx_q == 4'd0);

endmodule
